// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR sequence generator/checker family.
//   state_t : checker lock state encoding (ST_SEARCH / ST_LOCKED)
//   RUN_W   : width of the consecutive match/mismatch run counter
// -----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int RUN_W = 8;

endpackage

// File: rtl/prbs_checker_if.sv
// -----------------------------------------------------------------------------
// prbs_checker_if
// Bundles the checker's data/control inputs and status outputs.
//   master : drives enable, taps, data_in, clear; observes status
//   slave  : the checker side (consumes inputs, drives status)
// Status: locked, match, err_pulse, err_sticky, err_count[ERR_WIDTH-1:0]
// -----------------------------------------------------------------------------
interface prbs_checker_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_WIDTH = 16
);

  logic                 enable;
  logic [WIDTH-1:0]     taps;
  logic [WIDTH-1:0]     data_in;
  logic                 clear;
  logic                 locked;
  logic                 match;
  logic                 err_pulse;
  logic                 err_sticky;
  logic [ERR_WIDTH-1:0] err_count;

  modport master (
    output enable, taps, data_in, clear,
    input  locked, match, err_pulse, err_sticky, err_count
  );

  modport slave (
    input  enable, taps, data_in, clear,
    output locked, match, err_pulse, err_sticky, err_count
  );

endinterface

// File: rtl/lfsr_next_calc.sv
// -----------------------------------------------------------------------------
// lfsr_next_calc
// Combinational next-state function of the LFSR sequence.
//   cur  [WIDTH-1:0] : current word
//   taps [WIDTH-1:0] : bit n-1 gates feedback into bit n (MSB tap unused)
//   nxt  [WIDTH-1:0] : next word
// Feedback is MSB xor NOR(remaining bits), so the all-zero word is part of
// the sequence rather than a lock-up state.
// -----------------------------------------------------------------------------
module lfsr_next_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] nxt
);

  logic fdbk;
  logic unused_tap_msb;

  assign fdbk           = cur[WIDTH-1] ^ ~|cur[WIDTH-2:0];
  assign unused_tap_msb = taps[WIDTH-1];

  assign nxt[0]         = fdbk;
  assign nxt[WIDTH-1:1] = cur[WIDTH-2:0] ^ (taps[WIDTH-2:0] & {(WIDTH-1){fdbk}});

endmodule

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
// Predicts each received LFSR word from the previous one, acquires lock after
// LOCK_COUNT consecutive matches, drops lock after LOSS_COUNT consecutive
// mismatches, and counts errors while locked (saturating).
//   clk, rst_n : clock, asynchronous active-low reset
//   chk        : prbs_checker_if.slave (enable, taps, data_in, clear in;
//                locked, match, err_pulse, err_sticky, err_count out)
// Build option: define PRBS_CHECK_BIT_ERR_EN to count mismatched bits
// (popcount of data_in ^ prediction) instead of mismatched words.
// -----------------------------------------------------------------------------
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  prbs_checker_if.slave chk
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ERR_WIDTH + PC_W + 1;

  state_t               state;
  logic [WIDTH-1:0]     prev_word;
  logic                 prev_valid;
  logic [RUN_W-1:0]     run;
  logic                 match_q;
  logic                 err_pulse_q;
  logic                 err_sticky_q;
  logic [ERR_WIDTH-1:0] err_count_q;

  logic [WIDTH-1:0]     pred;
  logic                 cmp;
  logic [RUN_W:0]       run_inc;
  logic [PC_W-1:0]      err_inc;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Add with clamp at all-ones; the wide sum exposes any overflow.
  function automatic logic [ERR_WIDTH-1:0] sat_add(input logic [ERR_WIDTH-1:0] a,
                                                   input logic [PC_W-1:0]      b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({ERR_WIDTH{1'b1}})) begin
      return '1;
    end
    return s[ERR_WIDTH-1:0];
  endfunction

  lfsr_next_calc #(.WIDTH(WIDTH)) u_next (
    .cur  (prev_word),
    .taps (chk.taps),
    .nxt  (pred)
  );

  assign cmp     = prev_valid & (chk.data_in == pred);
  assign run_inc = {1'b0, run} + 1'b1;

`ifdef PRBS_CHECK_BIT_ERR_EN
  assign err_inc = popcount(chk.data_in ^ pred);
`else
  assign err_inc = PC_W'(1);
`endif

  // Compare stage: status registers reflect the sample taken this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_SEARCH;
      prev_word    <= '0;
      prev_valid   <= 1'b0;
      run          <= '0;
      match_q      <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      match_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      if (chk.enable) begin
        prev_word  <= chk.data_in;
        prev_valid <= 1'b1;
        match_q    <= cmp;
        case (state)
          ST_SEARCH: begin
            if (cmp) begin
              if (run_inc == (RUN_W+1)'(LOCK_COUNT)) begin
                state <= ST_LOCKED;
                run   <= '0;
              end else begin
                run <= run_inc[RUN_W-1:0];
              end
            end else begin
              run <= '0;
            end
          end
          ST_LOCKED: begin
            if (cmp) begin
              run <= '0;
            end else begin
              err_pulse_q  <= 1'b1;
              err_sticky_q <= 1'b1;
              err_count_q  <= sat_add(err_count_q, err_inc);
              if (run_inc == (RUN_W+1)'(LOSS_COUNT)) begin
                state <= ST_SEARCH;
                run   <= '0;
              end else begin
                run <= run_inc[RUN_W-1:0];
              end
            end
          end
          default: begin
            state <= ST_SEARCH;
            run   <= '0;
          end
        endcase
      end
      // clear wins over a same-cycle error update.
      if (chk.clear) begin
        err_count_q  <= '0;
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign chk.locked     = (state == ST_LOCKED);
  assign chk.match      = match_q;
  assign chk.err_pulse  = err_pulse_q;
  assign chk.err_sticky = err_sticky_q;
  assign chk.err_count  = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
// Directed bench for prbs_checker. Two instances: dut_a (ERR_WIDTH=16,
// LOSS_COUNT=4) and dut_b (ERR_WIDTH=4, LOSS_COUNT=255). Each driven word
// pushes the reference model's expected status into a queue; the entry is
// popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

  typedef struct {
    logic        locked;
    logic        match;
    logic        err_pulse;
    logic        err_sticky;
    logic [15:0] err_count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prbs_checker_if #(.WIDTH(8), .ERR_WIDTH(16)) bus_a ();
  prbs_checker_if #(.WIDTH(8), .ERR_WIDTH(4))  bus_b ();

  prbs_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(4), .ERR_WIDTH(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .chk   (bus_a)
  );

  prbs_checker #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(255), .ERR_WIDTH(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .chk   (bus_b)
  );

  exp_t       sbq[$];
  int         checks   = 0;
  int         failures = 0;
  int         sel      = 0;
  logic [7:0] taps     = 8'h1C;
  logic [7:0] cur;

  // Reference model state
  logic       m_locked;
  logic [7:0] m_prev;
  logic       m_pv;
  int         m_run, m_cnt, m_lock_n, m_loss_n, m_max;
  logic       m_sticky;

  function automatic logic [7:0] tnext(input logic [7:0] w, input logic [7:0] t);
    logic       f;
    logic [7:0] n;
    f    = w[7] ^ (w[6:0] == 7'd0);
    n[0] = f;
    for (int i = 1; i < 8; i++) n[i] = w[i-1] ^ (t[i-1] & f);
    return n;
  endfunction

  task automatic mreset(input int lock_n, input int loss_n, input int maxv);
    m_locked = 1'b0; m_prev = 8'h00; m_pv = 1'b0; m_run = 0; m_cnt = 0;
    m_sticky = 1'b0; m_lock_n = lock_n; m_loss_n = loss_n; m_max = maxv;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic get_obs(output exp_t o);
    if (sel == 0) begin
      o.locked = bus_a.locked; o.match = bus_a.match; o.err_pulse = bus_a.err_pulse;
      o.err_sticky = bus_a.err_sticky; o.err_count = bus_a.err_count;
    end else begin
      o.locked = bus_b.locked; o.match = bus_b.match; o.err_pulse = bus_b.err_pulse;
      o.err_sticky = bus_b.err_sticky; o.err_count = {12'h000, bus_b.err_count};
    end
  endtask

  task automatic drive(input logic en, input logic [7:0] d, input logic clr, input string tag);
    exp_t       e, o;
    logic [7:0] pred;
    logic       cmp;
    int         inc;
    @(negedge clk);
    if (sel == 0) begin
      bus_a.enable = en; bus_a.data_in = d; bus_a.clear = clr;
    end else begin
      bus_b.enable = en; bus_b.data_in = d; bus_b.clear = clr;
    end
    pred        = tnext(m_prev, taps);
    e.match     = 1'b0;
    e.err_pulse = 1'b0;
    if (en) begin
      cmp    = m_pv && (d == pred);
      m_prev = d;
      m_pv   = 1'b1;
      e.match = cmp;
      if (!m_locked) begin
        if (cmp) begin
          m_run++;
          if (m_run == m_lock_n) begin m_locked = 1'b1; m_run = 0; end
        end else m_run = 0;
      end else if (cmp) begin
        m_run = 0;
      end else begin
`ifdef PRBS_CHECK_BIT_ERR_EN
        inc = $countones(d ^ pred);
`else
        inc = 1;
`endif
        e.err_pulse = 1'b1;
        m_sticky    = 1'b1;
        m_cnt       = (m_cnt + inc > m_max) ? m_max : m_cnt + inc;
        m_run++;
        if (m_run == m_loss_n) begin m_locked = 1'b0; m_run = 0; end
      end
    end
    if (clr) begin m_cnt = 0; m_sticky = 1'b0; end
    e.locked     = m_locked;
    e.err_sticky = m_sticky;
    e.err_count  = 16'(m_cnt);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    get_obs(o);
    check_bit({tag, ".locked"},     o.locked,     e.locked);
    check_bit({tag, ".match"},      o.match,      e.match);
    check_bit({tag, ".err_pulse"},  o.err_pulse,  e.err_pulse);
    check_bit({tag, ".err_sticky"}, o.err_sticky, e.err_sticky);
    check_vec({tag, ".err_count"},  o.err_count,  e.err_count);
  endtask

  task automatic send_good(input string tag);
    logic [7:0] w;
    w = tnext(cur, taps);
    drive(1'b1, w, 1'b0, tag);
    cur = w;
  endtask

  task automatic send_bad(input logic [7:0] mask, input logic clr, input string tag);
    logic [7:0] w;
    w = tnext(cur, taps) ^ mask;
    drive(1'b1, w, clr, tag);
    cur = w;
  endtask

  initial begin
    bus_a.enable = 1'b0; bus_a.taps = taps; bus_a.data_in = 8'h00; bus_a.clear = 1'b0;
    bus_b.enable = 1'b0; bus_b.taps = taps; bus_b.data_in = 8'h00; bus_b.clear = 1'b0;
    rst_n = 1'b0;
    mreset(4, 4, 65535);
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst.locked",     bus_a.locked,     1'b0);
    check_bit("rst.match",      bus_a.match,      1'b0);
    check_bit("rst.err_pulse",  bus_a.err_pulse,  1'b0);
    check_bit("rst.err_sticky", bus_a.err_sticky, 1'b0);
    check_vec("rst.err_count",  bus_a.err_count,  16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed and first prediction: next(0x00) = 0x39 with taps 0x1C
    cur = 8'h00;
    drive(1'b1, 8'h00, 1'b0, "seed");
    drive(1'b1, 8'h39, 1'b0, "pred");
    cur = 8'h39;
    check_bit("pred_0x39", bus_a.match, 1'b1);
    send_good("run3");
    send_good("run4");
    send_good("run5");
    check_bit("locked_after5", bus_a.locked, 1'b1);
    send_good("locked_good");
    drive(1'b0, 8'hAA, 1'b0, "idle");

    // Single word error, then continue from the received word
    send_bad(8'h01, 1'b0, "word_err");
    check_bit("word_err_pulse", bus_a.err_pulse, 1'b1);
    check_vec("word_err_count", bus_a.err_count, 16'd1);
    send_good("after_err");
`ifdef PRBS_CHECK_BIT_ERR_EN
    send_bad(8'h03, 1'b0, "bit_err");
    check_vec("bit_err_count", bus_a.err_count, 16'd3);
    send_good("after_bit_err");
`endif
    send_good("clear");
    drive(1'b1, tnext(cur, taps), 1'b1, "clear_good");
    cur = tnext(cur, taps);
    check_vec("cleared_count", bus_a.err_count, 16'd0);

    // Loss of lock and relock
    repeat (4) send_bad(8'h01, 1'b0, "loss");
    check_bit("lost_lock", bus_a.locked, 1'b0);
    check_vec("loss_count", bus_a.err_count, 16'd4);
    repeat (4) send_good("relock");
    check_bit("relocked", bus_a.locked, 1'b1);
    check_vec("relock_count_held", bus_a.err_count, 16'd4);

    // Asynchronous reset mid-operation takes effect before the next edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_rst.locked", bus_a.locked, 1'b0);
    check_vec("async_rst.count",  bus_a.err_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mreset(4, 4, 65535);
    cur = 8'h00;
    drive(1'b1, 8'h00, 1'b0, "post_rst_seed");

    // Saturation on the 4-bit counter instance
    bus_a.enable = 1'b0;
    sel = 1;
    mreset(4, 255, 15);
    cur = 8'h00;
    drive(1'b1, 8'h00, 1'b0, "b_seed");
    repeat (5) send_good("b_lock");
    check_bit("b_locked", bus_b.locked, 1'b1);
    repeat (20) send_bad(8'h01, 1'b0, "b_sat");
    check_vec("b_sat_count", {12'h000, bus_b.err_count}, 16'd15);
    check_bit("b_still_locked", bus_b.locked, 1'b1);
    send_bad(8'h01, 1'b1, "b_clear_err");
    check_vec("b_clear_count", {12'h000, bus_b.err_count}, 16'd0);
    check_bit("b_clear_sticky", bus_b.err_sticky, 1'b0);
    check_bit("b_clear_pulse", bus_b.err_pulse, 1'b1);
    bus_b.clear = 1'b0;
    send_bad(8'h01, 1'b0, "b_after_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
